kuz_slayer_seq: RTL and testbench
=================================

Name: kuz_slayer_seq

Overview:
- Sequencer applying the Kuznyechik nonlinear S-layer to one 128-bit block.
- Streams the block's 16 bytes one per cycle through a single shared byte S-box (`table_convertion`), which the parent instantiates and wires to the sbox_* ports.
- Reassembles the 16 substituted bytes into a 128-bit result.
- Sits between the round controller and the byte S-box; lets one 8-bit table serve a full block instead of 16 copies.

Parameters:
- NUM_BYTES, 16, bytes per block; block width = 8*NUM_BYTES.
- IDLE_BYTE, 8'h00, value driven on sbox_in when not running.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request: begin processing din; honoured only when ready=1.
- din  in  8*NUM_BYTES  input block; bits [127:120] are byte 0, processed first.
- ready  out  1  high in IDLE; block accepts start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; dout is valid and updated in this cycle.
- dout  out  8*NUM_BYTES  substituted block, byte order identical to din.
- sbox_in  out  8  byte presented to the shared S-box.
- sbox_out  in  8  S-box result for sbox_in; combinational path.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: state=IDLE, ready=1, busy=0, done=0, dout=0, cnt=0, sbox_in=IDLE_BYTE.
- States:
  - IDLE: ready=1; sbox_in=IDLE_BYTE. On an edge with start=1, latch din into the input shift register, clear cnt, go to RUN.
  - RUN: sbox_in = input_sr[MSB byte].
    - Each edge: shift input_sr left 8; shift sbox_out into the low byte of result_sr; cnt += 1.
    - On the edge where cnt==NUM_BYTES-1: load dout with the completed result (last byte in the low position), set done=1, go to DONE.
  - DONE: done=1 for exactly this cycle; busy=1, ready=0. Next edge: done=0, go to IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E16 (16 cycles).
- Throughput: one block per 18 cycles (IDLE→RUN→DONE→IDLE).
- start while RUN or DONE is ignored and not queued. din is sampled only at acceptance, so later changes to din have no effect.
- dout holds its value until the next completion or reset; it is never partially updated.
- cnt width: clog2(NUM_BYTES). cnt never wraps past NUM_BYTES-1.
- rst mid-operation (RUN or DONE): job is dropped, all reset values restored, no done pulse.
- rst has priority over start on the same edge.

Optional Feature:
- Macro: KUZ_SLAYER_PIPE_EN.
- Defined:
  - sbox_out is captured into an internal register before entering result_sr (breaks the combinational S-box path).
  - RUN lasts NUM_BYTES+1 edges; the first capture is discarded as a bubble.
  - done follows edge E17 (17 cycles latency).
- Undefined: sbox_out is used directly, with 16 cycles latency as above.
- Ports, handshake and dout contents are identical in both cases.

Decomposition:
- Package kuz_pkg holds:
  - constants BLOCK_W=128, BYTE_W=8, NUM_BYTES=16;
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- No internal sub-module. The S-box is the existing `table_convertion`, instantiated by the parent and connected via sbox_in/sbox_out, so it can be shared or replaced.

Test Plan:
- After rst, start with din=ffeeddccbbaa99881122334455667700 → done once, 16 cycles later (17 with PIPE_EN); dout=b66cd8887d38e8d77765aeea0c9a7efc.
- Chain: feed the previous dout back as din → dout=559d8dd7bd06cbfe7e7b262523280d39. Check ready is low throughout RUN/DONE and high the cycle after done.
- din=0 → dout=fcfcfcfcfcfcfcfcfcfcfcfcfcfcfcfc. Monitor sbox_in sequence: 00 ×16, then IDLE_BYTE.
- Pulse start repeatedly during RUN, and change din mid-run → only one done pulse; dout reflects the originally latched din.
- Assert rst at cycle 8 of RUN → no done pulse; dout=0; ready=1 the next cycle. A subsequent start completes normally.
- start held high continuously → back-to-back blocks every 18 cycles; each done is exactly one cycle wide.

Source files
------------

// File: rtl/kuz_pkg.sv
// kuz_pkg: shared constants and state encoding for the Kuznyechik S-layer
// sequencer.
//   BLOCK_W   : cipher block width in bits
//   BYTE_W    : width of one S-box lane
//   NUM_BYTES : bytes per block
//   state_e   : sequencer states (IDLE / RUN / DONE)
package kuz_pkg;

  localparam int BLOCK_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/kuz_slayer_seq.sv
// kuz_slayer_seq: applies the Kuznyechik nonlinear S-layer to one 128-bit
// block by streaming its bytes, MSB byte first, through a single external
// byte S-box and reassembling the substituted bytes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin processing din (honoured only while ready=1)
//   din       in   input block, byte 0 in [127:120]
//   ready     out  high in IDLE
//   busy      out  high in RUN and DONE
//   done      out  one-cycle pulse, dout valid/updated in that cycle
//   dout      out  substituted block, same byte order as din
//   sbox_in   out  byte presented to the shared S-box
//   sbox_out  in   combinational S-box result for sbox_in
//
// Optional build macro KUZ_SLAYER_PIPE_EN: registers sbox_out before it
// enters the result register, adding one bubble cycle to RUN (latency 17
// instead of 16). Handshake and dout contents are unchanged.
module kuz_slayer_seq
  import kuz_pkg::*;
#(
  parameter int         NUM_BYTES = 16,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] din,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] dout,
  output logic [7:0]             sbox_in,
  input  logic [7:0]             sbox_out
);

  localparam int BW    = 8 * NUM_BYTES;
  localparam int CNT_W = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  state_e           r_state;
  logic [BW-1:0]    r_input_sr;
  logic [BW-1:0]    r_result_sr;
  logic [BW-1:0]    r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_new_byte;
  logic             w_shift_en;
  logic             w_last;

`ifdef KUZ_SLAYER_PIPE_EN
  logic [7:0]       r_sbox_q;
  logic             r_bubble;

  // The first RUN cycle only primes r_sbox_q; nothing valid to collect yet.
  assign w_new_byte = r_sbox_q;
  assign w_shift_en = ~r_bubble;
`else
  assign w_new_byte = sbox_out;
  assign w_shift_en = 1'b1;
`endif

  assign w_last = w_shift_en && (r_cnt == LAST_CNT);

  // Present the current MSB byte only while running; idle value otherwise.
  assign sbox_in = (r_state == RUN) ? r_input_sr[BW-1 -: BYTE_W] : IDLE_BYTE;

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign dout  = r_dout;

`ifdef KUZ_SLAYER_PIPE_EN
  // Capture stage for the S-box result; bubble flag marks the priming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sbox_q <= 8'h00;
      r_bubble <= 1'b0;
    end else if (r_state == IDLE) begin
      r_bubble <= start;
    end else if (r_state == RUN) begin
      r_sbox_q <= sbox_out;
      r_bubble <= 1'b0;
    end else begin
      r_bubble <= 1'b0;
    end
  end
`endif

  // Sequencer FSM with shift registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_input_sr  <= '0;
      r_result_sr <= '0;
      r_dout      <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_input_sr <= din;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_input_sr <= r_input_sr << BYTE_W;
          if (w_shift_en) begin
            r_result_sr <= {r_result_sr[BW-BYTE_W-1:0], w_new_byte};
            if (w_last) begin
              // dout is only ever written whole, on completion.
              r_dout  <= {r_result_sr[BW-BYTE_W-1:0], w_new_byte};
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kuz_slayer_seq.sv
// tb_kuz_slayer_seq: directed self-checking bench for kuz_slayer_seq.
// Provides the Kuznyechik Pi table as the shared combinational S-box.
module tb_kuz_slayer_seq;

`ifdef KUZ_SLAYER_PIPE_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif
  localparam int PER = LAT + 2;

  localparam logic [127:0] V0 = 128'hffeeddccbbaa99881122334455667700;
  localparam logic [127:0] E0 = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
  localparam logic [127:0] E1 = 128'h559d8dd7bd06cbfe7e7b262523280d39;
  localparam logic [127:0] EZ = 128'hfcfcfcfcfcfcfcfcfcfcfcfcfcfcfcfc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic         ready, busy, done;
  logic [127:0] dout;
  logic [7:0]   sbox_in, sbox_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pi_tab [0:255] = '{
    8'd252,8'd238,8'd221,8'd17,8'd207,8'd110,8'd49,8'd22,8'd251,8'd196,8'd250,8'd218,8'd35,8'd197,8'd4,8'd77,
    8'd233,8'd119,8'd240,8'd219,8'd147,8'd46,8'd153,8'd186,8'd23,8'd54,8'd241,8'd187,8'd20,8'd205,8'd95,8'd193,
    8'd249,8'd24,8'd101,8'd90,8'd226,8'd92,8'd239,8'd33,8'd129,8'd28,8'd60,8'd66,8'd139,8'd1,8'd142,8'd79,
    8'd5,8'd132,8'd2,8'd174,8'd227,8'd106,8'd143,8'd160,8'd6,8'd11,8'd237,8'd152,8'd127,8'd212,8'd211,8'd31,
    8'd235,8'd52,8'd44,8'd81,8'd234,8'd200,8'd72,8'd171,8'd242,8'd42,8'd104,8'd162,8'd253,8'd58,8'd206,8'd204,
    8'd181,8'd112,8'd14,8'd86,8'd8,8'd12,8'd118,8'd18,8'd191,8'd114,8'd19,8'd71,8'd156,8'd183,8'd93,8'd135,
    8'd21,8'd161,8'd150,8'd41,8'd16,8'd123,8'd154,8'd199,8'd243,8'd145,8'd120,8'd111,8'd157,8'd158,8'd178,8'd177,
    8'd50,8'd117,8'd25,8'd61,8'd255,8'd53,8'd138,8'd126,8'd109,8'd84,8'd198,8'd128,8'd195,8'd189,8'd13,8'd87,
    8'd223,8'd245,8'd36,8'd169,8'd62,8'd168,8'd67,8'd201,8'd215,8'd121,8'd214,8'd246,8'd124,8'd34,8'd185,8'd3,
    8'd224,8'd15,8'd236,8'd222,8'd122,8'd148,8'd176,8'd188,8'd220,8'd232,8'd40,8'd80,8'd78,8'd51,8'd10,8'd74,
    8'd167,8'd151,8'd96,8'd115,8'd30,8'd0,8'd98,8'd68,8'd26,8'd184,8'd56,8'd130,8'd100,8'd159,8'd38,8'd65,
    8'd173,8'd69,8'd70,8'd146,8'd39,8'd94,8'd85,8'd47,8'd140,8'd163,8'd165,8'd125,8'd105,8'd213,8'd149,8'd59,
    8'd7,8'd88,8'd179,8'd64,8'd134,8'd172,8'd29,8'd247,8'd48,8'd55,8'd107,8'd228,8'd136,8'd217,8'd231,8'd137,
    8'd225,8'd27,8'd131,8'd73,8'd76,8'd63,8'd248,8'd254,8'd141,8'd83,8'd170,8'd144,8'd202,8'd216,8'd133,8'd97,
    8'd32,8'd113,8'd103,8'd164,8'd45,8'd43,8'd9,8'd91,8'd203,8'd155,8'd37,8'd208,8'd190,8'd229,8'd108,8'd82,
    8'd89,8'd166,8'd116,8'd210,8'd230,8'd244,8'd180,8'd192,8'd209,8'd102,8'd175,8'd194,8'd57,8'd75,8'd99,8'd182
  };

  assign sbox_out = pi_tab[sbox_in];

  kuz_slayer_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block from IDLE; optionally disturbs start/din while running.
  task automatic run_block(input logic [127:0] d, input logic [127:0] e,
                           input string tag, input bit disturb);
    int cyc = 0;
    int rdy_hi = 0;
    int seq_err = 0;
    int extra = 0;
    logic [127:0] sh;
    check({tag, "_ready_pre"}, 128'(ready), 128'd1);
    din = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cyc < 40) begin
      if (ready) rdy_hi++;
      if (cyc < LAT) begin
        sh = d << (8 * cyc);
        if (sbox_in !== sh[127:120]) seq_err++;
      end
      if (disturb && cyc == 3) begin start = 1'b1; din = ~d; end
      if (disturb && cyc == 6) start = 1'b0;
      if (disturb && cyc == 9) din = 128'h0123456789abcdef0123456789abcdef;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 128'(cyc), 128'(LAT));
    check({tag, "_dout"}, dout, e);
    check({tag, "_ready_low"}, 128'(rdy_hi), 128'd0);
    check({tag, "_sbox_seq"}, 128'(seq_err), 128'd0);
    check({tag, "_busy_done"}, 128'(busy), 128'd1);
    tick();
    check({tag, "_done_1cyc"}, 128'(done), 128'd0);
    check({tag, "_ready_post"}, 128'(ready), 128'd1);
    check({tag, "_sbox_idle"}, 128'(sbox_in), 128'h00);
    if (disturb) begin
      for (int k = 0; k < 25; k++) begin
        if (done) extra++;
        tick();
      end
      check({tag, "_extra_done"}, 128'(extra), 128'd0);
      check({tag, "_dout_hold"}, dout, e);
    end
  endtask

  initial begin
    int seen_done;
    int nrise;
    int wide;
    int t_rise [0:7];
    logic prev_done;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_dout", dout, 128'd0);
    check("rst_sbox_in", 128'(sbox_in), 128'h00);

    // Main vector, chained vector, all-zero block
    run_block(V0, E0, "vec0", 1'b0);
    run_block(dout, E1, "chain", 1'b0);
    run_block(128'd0, EZ, "zero", 1'b0);

    // start pulses and din changes mid-run are ignored
    run_block(V0, E0, "disturb", 1'b1);

    // Reset in the middle of RUN drops the job
    din = E0;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen_done++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (done) seen_done++;
    check("midrst_no_done", 128'(seen_done), 128'd0);
    check("midrst_dout", dout, 128'd0);
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_busy", 128'(busy), 128'd0);
    for (int k = 0; k < 20; k++) begin
      if (done) seen_done++;
      tick();
    end
    check("midrst_quiet", 128'(seen_done), 128'd0);
    run_block(E0, E1, "after_rst", 1'b0);

    // start held high: back-to-back blocks
    din = V0;
    start = 1'b1;
    nrise = 0;
    wide = 0;
    prev_done = 1'b0;
    for (int t = 0; t < 4 * PER + 4; t++) begin
      tick();
      if (done && !prev_done) begin
        if (nrise < 8) t_rise[nrise] = t;
        nrise++;
        check("b2b_dout", dout, E0);
      end
      if (done && prev_done) wide++;
      prev_done = done;
    end
    start = 1'b0;
    check("b2b_count", 128'(nrise >= 4), 128'd1);
    check("b2b_first", 128'(t_rise[0]), 128'(LAT));
    check("b2b_period1", 128'(t_rise[1] - t_rise[0]), 128'(PER));
    check("b2b_period2", 128'(t_rise[2] - t_rise[1]), 128'(PER));
    check("b2b_period3", 128'(t_rise[3] - t_rise[2]), 128'(PER));
    check("b2b_width", 128'(wide), 128'd0);
    for (int k = 0; k < 40 && !(ready && !busy); k++) tick();
    check("b2b_drain_ready", 128'(ready), 128'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
